// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common with the receiver),
// data width, default bit period and the even-parity helper.
package uart_pkg;

   localparam int DATA_BITS              = 8;
   localparam int DEFAULT_CLOCKS_PER_BIT = 520;

   // State encodings are shared with the receiver; keep values stable.
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_STOP    = 3'd3;
   localparam logic [2:0] ST_CLEANUP = 3'd4;
   localparam logic [2:0] ST_PARITY  = 3'd5;

   // Even parity over one data byte (XOR of all bits).
   function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter. Counts 0..CLOCKS_PER_BIT-1 while enabled and emits a
// one-cycle terminal-count pulse on the last cycle of each bit period, then
// wraps to zero so the next period starts cleanly. Clear has priority.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
   parameter int CNT_W          = $clog2(CLOCKS_PER_BIT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(CLOCKS_PER_BIT - 1);

   logic [CNT_W-1:0] count_r;

   // Terminal count only while counting, so the pulse lasts exactly one cycle.
   assign tc = enable && (count_r == TC_VAL);

   // Count within the bit period; never exceeds TC_VAL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else if (enable) begin
         if (count_r == TC_VAL) begin
            count_r <= {CNT_W{1'b0}};
         end else begin
            count_r <= count_r + CNT_W'(1);
         end
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit (low), 8 data bits LSB first, stop bit (high).
// All outputs are registered from the next-state decode, so the line changes
// one cycle after acceptance and no input reaches an output combinationally.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the
// last data bit and the stop bit.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
   parameter int CNT_W          = $clog2(CLOCKS_PER_BIT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_serial,
   output logic                 tx_active,
   output logic                 tx_done
);

   logic [2:0]           state_r;
   logic [2:0]           state_s;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] shift_s;
   logic [2:0]           index_r;
   logic [2:0]           index_s;
   logic                 done_s;
   logic                 serial_s;
   logic                 active_s;
   logic                 cnt_en_s;
   logic                 cnt_clr_s;
   logic                 tc_s;
   logic                 tx_serial_r;
   logic                 tx_ready_r;
   logic                 tx_active_r;
   logic                 tx_done_r;

   uart_baud_counter #(
      .CLOCKS_PER_BIT (CLOCKS_PER_BIT),
      .CNT_W          (CNT_W)
   ) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (cnt_clr_s),
      .enable (cnt_en_s),
      .tc     (tc_s)
   );

   // Counter runs only in bit-carrying states; held at zero otherwise.
   always_comb begin
      cnt_en_s = 1'b0;
      case (state_r)
         ST_START,
`ifdef UART_TX_PARITY_EN
         ST_PARITY,
`endif
         ST_DATA,
         ST_STOP:  cnt_en_s = 1'b1;
         default:  cnt_en_s = 1'b0;
      endcase
      cnt_clr_s = !cnt_en_s;
   end

   // Next-state, shift register, bit index and done-pulse decode.
   always_comb begin
      state_s = state_r;
      shift_s = shift_r;
      index_s = index_r;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (tx_start) begin
               shift_s = tx_data;
               index_s = 3'd0;
               state_s = ST_START;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (tc_s) begin
               state_s = ST_DATA;
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (tc_s) begin
               if (index_r < 3'd7) begin
                  index_s = index_r + 3'd1;
                  state_s = ST_DATA;
               end else begin
                  index_s = 3'd0;
`ifdef UART_TX_PARITY_EN
                  state_s = ST_PARITY;
`else
                  state_s = ST_STOP;
`endif
               end
            end else begin
               state_s = ST_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tc_s) begin
               state_s = ST_STOP;
            end else begin
               state_s = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (tc_s) begin
               done_s  = 1'b1;
               state_s = ST_CLEANUP;
            end else begin
               state_s = ST_STOP;
            end
         end
         ST_CLEANUP: begin
            state_s = ST_IDLE;
         end
         default: begin
            // Unreachable encodings recover to IDLE with the line high.
            state_s = ST_IDLE;
            index_s = 3'd0;
         end
      endcase
   end

   // Output values for the state being entered, so registers line up with it.
   always_comb begin
      serial_s = 1'b1;
      active_s = 1'b0;
      case (state_s)
         ST_START: begin
            serial_s = 1'b0;
            active_s = 1'b1;
         end
         ST_DATA: begin
            serial_s = shift_s[index_s];
            active_s = 1'b1;
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            serial_s = even_parity(shift_s);
            active_s = 1'b1;
         end
`endif
         ST_STOP: begin
            serial_s = 1'b1;
            active_s = 1'b1;
         end
         default: begin
            serial_s = 1'b1;
            active_s = 1'b0;
         end
      endcase
   end

   // State, datapath and registered outputs; reset forces the line high at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         shift_r     <= {DATA_BITS{1'b0}};
         index_r     <= 3'd0;
         tx_serial_r <= 1'b1;
         tx_ready_r  <= 1'b1;
         tx_active_r <= 1'b0;
         tx_done_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         shift_r     <= shift_s;
         index_r     <= index_s;
         tx_serial_r <= serial_s;
         tx_ready_r  <= (state_s == ST_IDLE);
         tx_active_r <= active_s;
         tx_done_r   <= done_s;
      end
   end

   assign tx_serial = tx_serial_r;
   assign tx_ready  = tx_ready_r;
   assign tx_active = tx_active_r;
   assign tx_done   = tx_done_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at CLOCKS_PER_BIT=4. The expected
// line waveform is built from the frame definition (start, data LSB first,
// optional parity, stop) and compared every cycle together with the status
// flags. Define UART_TX_PARITY_EN for both DUT and bench to cover parity.
module tb_uart_transmitter;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = NBITS * CPB;

   logic       clk;
   logic       rst_n;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_serial;
   logic       tx_active;
   logic       tx_done;

   int checks_n;
   int errors_n;

   uart_transmitter #(.CLOCKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .tx_serial (tx_serial),
      .tx_active (tx_active),
      .tx_done   (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_n++;
      if (got !== exp) begin
         errors_n++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Line level for each bit period of a frame, index 0 = start bit.
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      logic [10:0] f;
      f    = 11'h7FF;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
      f[9]  = ^d;
      f[10] = 1'b1;
`else
      f[9]  = 1'b1;
`endif
      return f;
   endfunction

   // Status vector: {ready, active, done, serial}.
   function automatic logic [3:0] status();
      return {tx_ready, tx_active, tx_done, tx_serial};
   endfunction

   // Send one byte and check every cycle until ready returns. hold keeps
   // tx_start high (back-to-back); poke pulses tx_start mid-frame with pdata.
   task automatic run_frame(input logic [7:0] d, input bit hold, input bit poke,
                            input logic [7:0] pdata);
      logic [10:0] fr;
      int          to;
      int          k;
      fr = model_frame(d);
      to = 0;
      while (tx_ready !== 1'b1 && to < 200) begin
         @(negedge clk);
         to++;
      end
      check("ready_wait", {31'd0, tx_ready}, 32'd1);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      if (!hold) tx_start = 1'b0;
      tx_data = 8'($urandom);
      for (int c = 1; c <= FRAME_CYC; c++) begin
         k = (c - 1) / CPB;
         check("frame_line", {28'd0, status()}, {28'd0, 3'b010, fr[k]});
         if (poke && c == 3 * CPB) begin
            tx_start = 1'b1;
            tx_data  = pdata;
         end else if (poke && c == 3 * CPB + 1) begin
            tx_start = hold;
         end
         @(negedge clk);
      end
      check("done_pulse", {28'd0, status()}, {28'd0, 4'b0011});
      @(negedge clk);
      check("ready_back", {28'd0, status()}, {28'd0, 4'b1001});
   endtask

   initial begin
      checks_n = 0;
      errors_n = 0;
      rst_n    = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_state", {28'd0, status()}, {28'd0, 4'b1001});
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {28'd0, status()}, {28'd0, 4'b1001});

      // Directed frames, including a busy-time start that must be ignored.
      run_frame(8'hA5, 1'b0, 1'b0, 8'h00);
      run_frame(8'h3C, 1'b0, 1'b1, 8'hFF);
      run_frame(8'h07, 1'b0, 1'b0, 8'h00);
      run_frame(8'h03, 1'b0, 1'b0, 8'h00);
      repeat (2) @(negedge clk);
      check("idle_no_queue", {28'd0, status()}, {28'd0, 4'b1001});

      // Back-to-back with tx_start held: two line-high cycles between frames.
      run_frame(8'h00, 1'b1, 1'b0, 8'h00);
      run_frame(8'h7E, 1'b1, 1'b0, 8'h00);
      tx_start = 1'b0;
      @(negedge clk);
      check("b2b_released", {28'd0, status()}, {28'd0, 4'b1001});

      // Reset during data bit 3 of 8'h00: line low, then high asynchronously.
      tx_data  = 8'h00;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (4 * CPB + 1) @(negedge clk);
      check("mid_frame_low", {28'd0, status()}, {28'd0, 4'b0100});
      #2 rst_n = 1'b0;
      #1 check("async_reset", {28'd0, status()}, {28'd0, 4'b1001});
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3 * CPB; c++) begin
         @(negedge clk);
         check("post_reset_idle", {28'd0, status()}, {28'd0, 4'b1001});
      end

      // Randomized frames with random busy-time pokes.
      for (int i = 0; i < 12; i++) begin
         run_frame(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
      $finish;
   end

endmodule
